// File: rtl/dcm_chain_lock_sequencer_if.sv
// dcm_chain_lock_sequencer_if: lock inputs and reset/status outputs of the DLL chain sequencer
interface dcm_chain_lock_sequencer_if #(
  parameter int NUM_STAGES = 2,
  parameter int RETRY_W = 4
);
  localparam int CS_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  logic [NUM_STAGES-1:0] stage_locked;
  logic retry_clr;
  logic [NUM_STAGES-1:0] stage_rst;
  logic sys_rst;
  logic all_locked;
  logic fault;
  logic [RETRY_W-1:0] retry_count;
  logic [CS_W-1:0] cur_stage;
  modport master (
    output stage_locked, retry_clr,
    input stage_rst, sys_rst, all_locked, fault, retry_count, cur_stage
  );
  modport slave (
    input stage_locked, retry_clr,
    output stage_rst, sys_rst, all_locked, fault, retry_count, cur_stage
  );
endinterface

// File: rtl/dcm_chain_lock_sequencer.sv
// dcm_chain_lock_sequencer: brings a cascade of DLL stages up one at a time and releases sys_rst once all are qualified
module dcm_chain_lock_sequencer #(
  parameter int NUM_STAGES = 2,
  parameter int RST_PULSE_CYCLES = 3,
  parameter int QUAL_CYCLES = 8,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRIES = 3,
  parameter int RETRY_W = 4
) (
  input logic clk,
  input logic ares,
  dcm_chain_lock_sequencer_if.slave bus
);
  localparam int CS_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int QW = $clog2(QUAL_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int PW = $clog2(RST_PULSE_CYCLES + 1);
  typedef enum logic [2:0] {S_RESET_ALL, S_WAIT_LOCK, S_QUALIFY, S_RUN, S_FAULT} state_t;
  state_t r_state, w_state_nxt;
  logic [NUM_STAGES-1:0] r_sync1, r_lk, r_stage_rst, w_stage_rst_nxt, w_mask, w_drop;
  logic [CS_W-1:0] r_cur, w_cur_nxt, r_restart, w_restart_nxt, w_drop_idx;
  logic [RETRY_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
  logic [QW-1:0] r_qcnt, w_qcnt_nxt;
  logic [TW-1:0] r_tcnt, w_tcnt_nxt;
  logic [PW-1:0] r_pcnt, w_pcnt_nxt;
  logic r_sys_rst, r_all_locked, r_fault, w_lk_cur, w_last, w_can_retry;
  assign w_lk_cur = r_lk[r_cur];
  assign w_last = r_cur == CS_W'(NUM_STAGES - 1);
  assign w_can_retry = int'(r_retry) < MAX_RETRIES;
  assign w_retry_inc = (&r_retry) ? r_retry : r_retry + 1'b1;
  // stages already qualified: everything in RUN, only those below cur_stage while bringing up
  assign w_mask = (r_state == S_RUN) ? '1 : (NUM_STAGES'(1) << r_cur) - 1'b1;
  assign w_drop = ~r_lk & w_mask;
  // lowest dropped stage wins so everything above it is restarted together
  always_comb begin
    w_drop_idx = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) w_drop_idx = w_drop[k] ? CS_W'(k) : w_drop_idx;
  end
  // next-state and counter updates
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt = r_cur;
    w_restart_nxt = r_restart;
    w_retry_nxt = r_retry;
    w_qcnt_nxt = r_qcnt;
    w_tcnt_nxt = (r_tcnt == TW'(LOCK_TIMEOUT)) ? r_tcnt : r_tcnt + 1'b1;
    w_pcnt_nxt = '0;
    case (r_state)
      S_RESET_ALL:
        if (r_pcnt == PW'(RST_PULSE_CYCLES - 1)) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cur_nxt = r_restart;
          w_qcnt_nxt = '0;
          w_tcnt_nxt = '0;
        end else w_pcnt_nxt = r_pcnt + 1'b1;
      S_WAIT_LOCK, S_QUALIFY:
        if (|w_drop) begin
          w_state_nxt = S_RESET_ALL;
          w_restart_nxt = w_drop_idx;
        end else if (r_tcnt == TW'(LOCK_TIMEOUT)) begin
          w_state_nxt = w_can_retry ? S_RESET_ALL : S_FAULT;
          w_retry_nxt = w_can_retry ? w_retry_inc : r_retry;
          w_restart_nxt = '0;
        end else if (r_state == S_WAIT_LOCK) begin
          w_state_nxt = w_lk_cur ? S_QUALIFY : S_WAIT_LOCK;
          w_qcnt_nxt = '0;
        end else if (!w_lk_cur) begin
          w_state_nxt = S_WAIT_LOCK;
          w_qcnt_nxt = '0;
        end else if (r_qcnt == QW'(QUAL_CYCLES)) begin
          w_state_nxt = w_last ? S_RUN : S_WAIT_LOCK;
          w_cur_nxt = w_last ? r_cur : r_cur + 1'b1;
          w_tcnt_nxt = '0;
        end else w_qcnt_nxt = r_qcnt + 1'b1;
      S_RUN:
        if (|w_drop) begin
          w_state_nxt = S_RESET_ALL;
          w_restart_nxt = w_drop_idx;
        end
      S_FAULT:
        if (bus.retry_clr) begin
          w_state_nxt = S_RESET_ALL;
          w_retry_nxt = '0;
          w_restart_nxt = '0;
        end
      default: w_state_nxt = S_RESET_ALL;
    endcase
  end
  // per-stage reset pattern for the state being entered
  always_comb begin
    w_stage_rst_nxt = '0;
    for (int k = 0; k < NUM_STAGES; k++)
      w_stage_rst_nxt[k] = (w_state_nxt == S_FAULT) ||
        (w_state_nxt == S_RESET_ALL && k >= int'(w_restart_nxt)) ||
        ((w_state_nxt == S_WAIT_LOCK || w_state_nxt == S_QUALIFY) && k > int'(w_cur_nxt));
  end
  // lock synchronisers, state, counters and registered outputs
  always_ff @(posedge clk or posedge ares)
    if (ares) begin
      r_sync1 <= '0;
      r_lk <= '0;
      r_state <= S_RESET_ALL;
      r_cur <= '0;
      r_restart <= '0;
      r_retry <= '0;
      r_qcnt <= '0;
      r_tcnt <= '0;
      r_pcnt <= '0;
      r_stage_rst <= '1;
      r_sys_rst <= 1'b1;
      r_all_locked <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_sync1 <= bus.stage_locked;
      r_lk <= r_sync1;
      r_state <= w_state_nxt;
      r_cur <= w_cur_nxt;
      r_restart <= w_restart_nxt;
      r_retry <= w_retry_nxt;
      r_qcnt <= w_qcnt_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_pcnt <= w_pcnt_nxt;
      r_stage_rst <= w_stage_rst_nxt;
      r_sys_rst <= !(r_state == S_RUN && w_state_nxt == S_RUN);
      r_all_locked <= w_state_nxt == S_RUN;
      r_fault <= w_state_nxt == S_FAULT;
    end
  assign bus.stage_rst = r_stage_rst;
  assign bus.sys_rst = r_sys_rst;
  assign bus.all_locked = r_all_locked;
  assign bus.fault = r_fault;
  assign bus.retry_count = r_retry;
  assign bus.cur_stage = r_cur;
endmodule

// File: tb/tb_dcm_chain_lock_sequencer.sv
// tb_dcm_chain_lock_sequencer: directed lock scenarios with cycle-stamped expectations checked by a monitor
module tb_dcm_chain_lock_sequencer;
  localparam int F_RST = 0, F_SYS = 1, F_ALL = 2, F_FLT = 3, F_RTY = 4, F_CUR = 5;
  typedef struct { int c; int f; int v; string n; } exp_t;
  logic clk = 0;
  logic ares = 0;
  int cyc = 0, checks = 0, passed = 0, got;
  int b, b2, b3, b4;
  exp_t q[$];
  dcm_chain_lock_sequencer_if #(.NUM_STAGES(2), .RETRY_W(4)) bus();
  dcm_chain_lock_sequencer #(
    .NUM_STAGES(2), .RST_PULSE_CYCLES(3), .QUAL_CYCLES(8),
    .LOCK_TIMEOUT(100), .MAX_RETRIES(3), .RETRY_W(4)
  ) dut (.clk(clk), .ares(ares), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int getf(int f);
    return f == F_RST ? int'(bus.stage_rst) : f == F_SYS ? int'(bus.sys_rst) :
           f == F_ALL ? int'(bus.all_locked) : f == F_FLT ? int'(bus.fault) :
           f == F_RTY ? int'(bus.retry_count) : int'(bus.cur_stage);
  endfunction
  task automatic ex(int c, int f, int v, string n);
    q.push_back('{c, f, v, n});
  endtask
  task automatic ex_reset(int c, string n);
    ex(c, F_RST, 3, {n, "_stage_rst"});
    ex(c, F_SYS, 1, {n, "_sys_rst"});
    ex(c, F_ALL, 0, {n, "_all_locked"});
    ex(c, F_FLT, 0, {n, "_fault"});
    ex(c, F_RTY, 0, {n, "_retry_count"});
    ex(c, F_CUR, 0, {n, "_cur_stage"});
  endtask
  task automatic go(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset(output int base);
    ares = 1;
    repeat (2) @(posedge clk);
    #1;
    ares = 0;
    base = cyc;
  endtask
  // monitor: compares every expectation stamped for the current cycle, flags stale ones
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].c <= cyc) begin
        checks++;
        got = getf(q[i].f);
        if (q[i].c == cyc && got == q[i].v) passed++;
        else $display("FAIL %s at cycle %0d (due %0d): got %0d expected %0d", q[i].n, cyc, q[i].c, got, q[i].v);
        q.delete(i);
      end
  initial begin
    bus.stage_locked = 2'b00;
    bus.retry_clr = 0;
    #2;
    // bring-up: lock[0] first sampled at cycle 10, lock[1] at cycle 40
    do_reset(b);
    ex_reset(b, "rst");
    ex(b + 2, F_RST, 3, "pulse_end");
    ex(b + 3, F_RST, 2, "stage0_released");
    ex(b + 20, F_RST, 2, "stage1_still_held");
    ex(b + 21, F_RST, 0, "stage1_released");
    ex(b + 21, F_CUR, 1, "cur_stage1");
    ex(b + 50, F_ALL, 0, "not_run_yet");
    ex(b + 51, F_ALL, 1, "run_entered");
    ex(b + 51, F_SYS, 1, "sys_rst_delay");
    ex(b + 52, F_SYS, 0, "sys_rst_released");
    ex(b + 52, F_RTY, 0, "no_retries");
    go(b + 9);
    bus.stage_locked[0] = 1;
    go(b + 39);
    bus.stage_locked[1] = 1;
    // one-cycle drop of lock[1] in RUN restarts stage 1 only
    ex(b + 61, F_ALL, 1, "run_before_drop");
    ex(b + 62, F_ALL, 0, "drop1_all_locked");
    ex(b + 62, F_SYS, 1, "drop1_sys_rst");
    ex(b + 62, F_RST, 2, "drop1_rst_a");
    ex(b + 64, F_RST, 2, "drop1_rst_c");
    ex(b + 65, F_RST, 0, "drop1_wait");
    ex(b + 75, F_ALL, 1, "drop1_rerun");
    ex(b + 76, F_SYS, 0, "drop1_sys_rel");
    ex(b + 76, F_RTY, 0, "drop1_no_retry");
    go(b + 59);
    bus.stage_locked[1] = 0;
    go(b + 60);
    bus.stage_locked[1] = 1;
    // simultaneous drop of both locks restarts from stage 0
    ex(b + 92, F_RST, 3, "drop2_rst_a");
    ex(b + 92, F_ALL, 0, "drop2_all_locked");
    ex(b + 94, F_RST, 3, "drop2_rst_c");
    ex(b + 95, F_RST, 2, "drop2_wait0");
    ex(b + 95, F_CUR, 0, "drop2_cur0");
    ex(b + 105, F_RST, 0, "drop2_stage1");
    ex(b + 115, F_ALL, 1, "drop2_rerun");
    ex(b + 116, F_SYS, 0, "drop2_sys_rel");
    go(b + 89);
    bus.stage_locked = 2'b00;
    go(b + 90);
    bus.stage_locked = 2'b11;
    go(b + 117);
    // glitch on lock[0] after five qualified samples restarts qualification
    bus.stage_locked = 2'b00;
    do_reset(b2);
    ex(b2 + 13, F_RST, 2, "glitch_wait");
    ex(b2 + 16, F_RST, 2, "glitch_no_early");
    ex(b2 + 24, F_RST, 2, "glitch_held");
    ex(b2 + 25, F_RST, 0, "glitch_released");
    ex(b2 + 25, F_CUR, 1, "glitch_cur1");
    go(b2 + 4);
    bus.stage_locked[0] = 1;
    go(b2 + 10);
    bus.stage_locked[0] = 0;
    go(b2 + 13);
    bus.stage_locked[0] = 1;
    go(b2 + 26);
    // no lock at all: three retries then FAULT, retry_clr recovers
    bus.stage_locked = 2'b00;
    do_reset(b3);
    ex(b3 + 103, F_RTY, 0, "to_before_1");
    ex(b3 + 104, F_RTY, 1, "to_retry1");
    ex(b3 + 104, F_RST, 3, "to_restart_rst");
    ex(b3 + 151, F_RTY, 1, "clr_ignored");
    ex(b3 + 151, F_FLT, 0, "clr_no_fault");
    ex(b3 + 208, F_RTY, 2, "to_retry2");
    ex(b3 + 312, F_RTY, 3, "to_retry3");
    ex(b3 + 415, F_FLT, 0, "to_before_fault");
    ex(b3 + 416, F_FLT, 1, "to_fault");
    ex(b3 + 416, F_RST, 3, "fault_rst");
    ex(b3 + 416, F_SYS, 1, "fault_sys_rst");
    ex(b3 + 419, F_FLT, 1, "fault_held");
    ex(b3 + 420, F_FLT, 0, "clr_fault");
    ex(b3 + 420, F_RTY, 0, "clr_retry");
    ex(b3 + 420, F_RST, 3, "clr_reset_all");
    ex(b3 + 423, F_RST, 2, "clr_restart");
    go(b3 + 149);
    bus.retry_clr = 1;
    go(b3 + 150);
    bus.retry_clr = 0;
    go(b3 + 419);
    bus.retry_clr = 1;
    go(b3 + 420);
    bus.retry_clr = 0;
    go(b3 + 424);
    // asynchronous reset while qualifying stage 1
    bus.stage_locked = 2'b11;
    do_reset(b4);
    ex(b4 + 15, F_RST, 0, "qual1_rst");
    ex(b4 + 15, F_CUR, 1, "qual1_cur");
    ex(b4 + 15, F_SYS, 1, "qual1_sys");
    go(b4 + 16);
    ares = 1;
    #1;
    checks++;
    if (bus.stage_rst == 2'b11 && bus.sys_rst == 1'b1 && bus.all_locked == 1'b0 && bus.fault == 1'b0) passed++;
    else $display("FAIL ares_async_rst: stage_rst %0d sys_rst %0d all_locked %0d fault %0d", bus.stage_rst, bus.sys_rst, bus.all_locked, bus.fault);
    checks++;
    if (bus.retry_count == 4'd0 && bus.cur_stage == 1'b0) passed++;
    else $display("FAIL ares_async_cnt: retry_count %0d cur_stage %0d", bus.retry_count, bus.cur_stage);
    ex_reset(b4 + 16, "ares");
    go(b4 + 18);
    ares = 0;
    go(b4 + 20);
    foreach (q[i]) begin
      checks++;
      $display("FAIL %s never checked: got none expected %0d", q[i].n, q[i].v);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dcm_chain_lock_sequencer.md
Name: dcm_chain_lock_sequencer

Overview:
- Parametrised reset/lock sequencer for a cascade of NUM_STAGES clock-multiplying DLL/DCM stages, each stage fed by the previous stage's output.
- Generalises the fixed two-stage, 8-deep locked-shift gating to N stages with lock qualification, a lock timeout with bounded retries, and loss-of-lock recovery.
- Runs on the free-running crystal clock taken before the first DLL, so it keeps operating while every DLL is unlocked.
- Produces the per-stage DLL resets and the system reset that is released once the whole chain is qualified.

Parameters:
- NUM_STAGES, 2, number of cascaded DLL stages (1..8).
- RST_PULSE_CYCLES, 3, minimum clk cycles that every stage reset is held in RESET_ALL (≥3 per DCM requirement).
- QUAL_CYCLES, 8, consecutive synchronised-locked samples required before a stage is considered locked.
- LOCK_TIMEOUT, 65535, clk cycles allowed per stage from reset release to qualification.
- MAX_RETRIES, 3, number of timeout restarts before entering FAULT.
- RETRY_W, 4, width of retry_count (saturating).

Ports:
- clk  in  1  free-running crystal clock (pre-DLL).
- ares  in  1  asynchronous active-high reset.
- stage_locked  in  NUM_STAGES  raw LOCKED outputs of the DLLs; asynchronous to clk.
- retry_clr  in  1  single-cycle pulse; leaves FAULT and restarts the sequence.
- stage_rst  out  NUM_STAGES  active-high DLL resets; bit k drives stage k.
- sys_rst  out  1  active-high reset for logic clocked by the final DLL output.
- all_locked  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_count  out  RETRY_W  number of timeout restarts since ares or retry_clr; saturates at all-ones.
- cur_stage  out  max(1,clog2(NUM_STAGES))  index of the stage currently being brought up.

Behaviour:
- Every stage_locked bit passes through a 2-flop synchroniser. All decisions use the synchronised value lk[k].
- Reset values (all outputs registered): stage_rst all ones; sys_rst 1; all_locked 0; fault 0; retry_count 0; cur_stage 0; state RESET_ALL.
- RESET_ALL:
  - Hold all stage_rst high for RST_PULSE_CYCLES cycles.
  - Then set cur_stage to the restart index and go to WAIT_LOCK.
- WAIT_LOCK (stage k = cur_stage):
  - stage_rst[k] and all lower bits are low; bits above k are high.
  - Stay while lk[k] is 0.
  - Move to QUALIFY on the first cycle lk[k] is 1.
- QUALIFY:
  - The qualification counter increments each cycle lk[k] is 1.
  - If lk[k] is 0, clear the counter and return to WAIT_LOCK.
  - When the counter reaches QUAL_CYCLES:
    - if k < NUM_STAGES-1, increment cur_stage and go to WAIT_LOCK;
    - otherwise go to RUN.
  - Latency rule: stage_rst[k+1] falls exactly QUAL_CYCLES+3 clk edges after the first edge that samples stage_locked[k] high, provided that input stays high throughout.
- Timeout:
  - The timeout counter clears on entry to WAIT_LOCK for a new stage.
  - It counts in WAIT_LOCK and QUALIFY.
  - On reaching LOCK_TIMEOUT:
    - if retries < MAX_RETRIES, increment retry_count and go to RESET_ALL with restart index 0;
    - otherwise go to FAULT.
- Loss of lock:
  - In WAIT_LOCK, QUALIFY or RUN, if lk[j] = 0 for some already-qualified stage j (j < cur_stage, or any j in RUN), go to RESET_ALL with restart index j.
  - In that RESET_ALL, only stage_rst[j] and the bits above it are asserted; stages below j stay released.
  - retry_count is not incremented.
  - If several stages drop in the same cycle, the lowest index wins.
- RUN:
  - all_locked = 1.
  - sys_rst deasserts on the cycle after entering RUN.
  - On leaving RUN, sys_rst and all_locked change on the same edge as the state change, i.e. one clk after lk drops.
- FAULT:
  - All stage_rst high, sys_rst high, fault = 1.
  - Stays in FAULT until ares or retry_clr.
  - retry_clr clears retry_count and goes to RESET_ALL with restart index 0.
  - retry_clr is ignored in every other state.
- sys_rst is high in every state except RUN.
- ares asserted mid-sequence returns everything to reset values immediately (asynchronously).
- Counter widths:
  - the qualification counter holds QUAL_CYCLES;
  - the timeout counter holds LOCK_TIMEOUT;
  - neither wraps, as both stop at their terminal value.

Test Plan:
- Defaults, LOCK_TIMEOUT=100. Release ares; raise stage_locked[0] at cycle 10 and [1] at cycle 40 → stage_rst = 11 for cycles 0–2, 10 from cycle 3, 00 from cycle 21; sys_rst falls at cycle 52; all_locked = 1; retry_count = 0.
- Glitch stage_locked[0] low for 3 cycles after 5 qualified samples → qualification restarts; stage_rst[1] stays high until 11 clean cycles (QUAL_CYCLES+3) after the glitch ends.
- In RUN, drop stage_locked[1] for 1 cycle → sys_rst=1 and all_locked=0 within 3 edges; stage_rst = 10 for 3 cycles; stage_rst[0] stays 0; re-qualification returns to RUN; retry_count = 0.
- In RUN, drop stage_locked[0] and [1] on the same edge → restart index 0; stage_rst = 11 for 3 cycles.
- Hold stage_locked all low, LOCK_TIMEOUT=100 → retry_count steps 1, 2, 3; the 4th timeout gives fault = 1 with all stage_rst high; a retry_clr pulse → fault = 0, retry_count = 0, sequence restarts.
- Assert ares during QUALIFY of stage 1 → all outputs return to reset values without waiting for a clk edge.
